// File: rtl/opc6_mem_arbiter.sv
// opc6_mem_arbiter: shares one synchronous single-port RAM between the opc6 CPU
// and NREQ DMA requesters, one access per clock. A DMA slot taken while the CPU
// wants memory stalls the CPU through cpu_clken, and the CPU's read data is held
// steady across stalls and DMA reads.
module opc6_mem_arbiter #(
  parameter int NREQ         = 2,
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      cpu_address,
  input  logic [DW-1:0]      cpu_dout,
  input  logic               cpu_rnw,
  input  logic               cpu_vpa,
  input  logic               cpu_vda,
  output logic [DW-1:0]      cpu_din,
  output logic               cpu_clken,
  input  logic [NREQ-1:0]    dma_req,
  input  logic [NREQ*AW-1:0] dma_addr,
  input  logic [NREQ-1:0]    dma_we,
  input  logic [NREQ*DW-1:0] dma_wdata,
  output logic [NREQ-1:0]    dma_gnt,
  output logic [NREQ-1:0]    dma_rvalid,
  output logic [DW-1:0]      dma_rdata,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic               mem_ce,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  logic          cpu_req, any_dma, starved, own_cpu, own_dma;
  logic [IW-1:0] rr_ptr, pick_p0;
  logic [CW-1:0] starve_cnt;
  logic          cpu_mem_p1, dma_rd_vld_p1;
  logic [IW-1:0] dma_idx_p1;
  logic [DW-1:0] din_hold;

  // Requester index increment, wrapping at NREQ-1 so non-power-of-two counts work.
  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NREQ - 1)) ? '0 : v + 1'b1;
  endfunction

  // First requesting index at or after ptr, searching round the ring.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] idx, pick;
    logic          found;
    idx   = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = wrap_inc(idx);
    end
    return pick;
  endfunction

  // Starvation counter increment that sticks at the limit.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v >= CW'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  // Slot ownership: reset forces CPU, a starved DMA beats the CPU, else CPU first.
  always_comb begin
    cpu_req = cpu_vpa | cpu_vda;
    any_dma = |dma_req;
    pick_p0 = rr_pick(dma_req, rr_ptr);
    starved = any_dma && (starve_cnt == CW'(STARVE_LIMIT));
    own_dma = !reset && any_dma && (starved || !cpu_req);
    own_cpu = !own_dma && (reset || cpu_req);
  end

  // RAM port steering and grant for the current slot owner.
  always_comb begin
    mem_addr  = cpu_address;
    mem_wdata = cpu_dout;
    mem_we    = 1'b0;
    mem_ce    = 1'b0;
    dma_gnt   = '0;
    if (own_dma) begin
      mem_addr         = dma_addr[pick_p0*AW +: AW];
      mem_wdata        = dma_wdata[pick_p0*DW +: DW];
      mem_we           = dma_we[pick_p0];
      mem_ce           = 1'b1;
      dma_gnt[pick_p0] = 1'b1;
    end else if (own_cpu) begin
      mem_ce = cpu_req;
      mem_we = !reset && !cpu_rnw;
    end
  end

  // The CPU only stalls when it actually wanted the slot a DMA took.
  assign cpu_clken = !(own_dma && cpu_req);

  // Arbitration state and the record of who owned the previous slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr        <= '0;
      starve_cnt    <= '0;
      cpu_mem_p1    <= 1'b0;
      dma_rd_vld_p1 <= 1'b0;
      din_hold      <= '0;
    end else begin
      if (own_dma) begin
        rr_ptr     <= wrap_inc(pick_p0);
        starve_cnt <= '0;
      end else if (!any_dma) begin
        starve_cnt <= '0;
      end else if (own_cpu) begin
        starve_cnt <= sat_inc(starve_cnt);
      end
      cpu_mem_p1    <= own_cpu;
      dma_rd_vld_p1 <= own_dma && !dma_we[pick_p0];
      if (cpu_mem_p1) din_hold <= mem_rdata;
    end
  end

  // Requester index of the previous slot, qualified by dma_rd_vld_p1.
  always_ff @(posedge clk) begin
    dma_idx_p1 <= pick_p0;
  end

  // ---- p1: read return stage ----
  // Return-side steering of RAM read data to the previous slot's owner.
  always_comb begin
    dma_rvalid = '0;
    if (dma_rd_vld_p1 && !reset) dma_rvalid[dma_idx_p1] = 1'b1;
    dma_rdata = mem_rdata;
    cpu_din   = cpu_mem_p1 ? mem_rdata : din_hold;
  end

endmodule

// File: tb/tb_opc6_mem_arbiter.sv
// Directed testbench for opc6_mem_arbiter with a behavioural synchronous RAM.
module tb_opc6_mem_arbiter;

  logic        clk, reset;
  logic [15:0] cpu_address, cpu_dout, cpu_din;
  logic        cpu_rnw, cpu_vpa, cpu_vda, cpu_clken;
  logic [1:0]  dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [31:0] dma_addr, dma_wdata;
  logic [15:0] dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_ce;

  logic        pre_we;
  logic [15:0] pre_addr, pre_data;
  logic [15:0] ram [0:65535];

  int checks = 0;
  int errors = 0;

  opc6_mem_arbiter #(.NREQ(2), .AW(16), .DW(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
    .cpu_vpa(cpu_vpa), .cpu_vda(cpu_vda), .cpu_din(cpu_din), .cpu_clken(cpu_clken),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_ce(mem_ce), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM with a preload port for the bench.
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (mem_ce) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_address = 16'h0010; dma_req = 2'b11;
    #1;
    checks++; if (cpu_clken !== 1'b1) begin errors++; $display("FAIL rst_clken: got %b expected 1", cpu_clken); end
    checks++; if (dma_gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b expected 00", dma_gnt); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_ce !== 1'b1) begin errors++; $display("FAIL rst_mem_ce: got %b expected 1", mem_ce); end
    checks++; if (dma_rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b expected 00", dma_rvalid); end
    tick();
    reset = 1'b0; cpu_vpa = 1'b0; dma_req = 2'b00;
    #1;
    checks++; if (cpu_din !== 16'h0000) begin errors++; $display("FAIL rst_din: got %h expected 0000", cpu_din); end
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL idle_mem_ce: got %b expected 0", mem_ce); end
    tick();
  endtask

  task automatic test_cpu_only();
    cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_address = 16'h0010;
    #1;
    checks++; if (cpu_clken !== 1'b1) begin errors++; $display("FAIL cpu_clken_a: got %b expected 1", cpu_clken); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL cpu_addr_a: got %h expected 0010", mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_ce !== 1'b1) begin errors++; $display("FAIL cpu_ctl_a: got we=%b ce=%b expected we=0 ce=1", mem_we, mem_ce); end
    tick();
    cpu_address = 16'h0020;
    #1;
    checks++; if (cpu_din !== 16'h1234) begin errors++; $display("FAIL cpu_din_b: got %h expected 1234", cpu_din); end
    checks++; if (cpu_clken !== 1'b1) begin errors++; $display("FAIL cpu_clken_b: got %b expected 1", cpu_clken); end
    tick();
    cpu_vpa = 1'b0;
    #1;
    checks++; if (cpu_din !== 16'hBEEF) begin errors++; $display("FAIL cpu_din_c: got %h expected beef", cpu_din); end
    checks++; if (mem_ce !== 1'b0) begin errors++; $display("FAIL cpu_idle_ce: got %b expected 0", mem_ce); end
    tick();
    cpu_vda = 1'b1; cpu_rnw = 1'b0; cpu_address = 16'h0070; cpu_dout = 16'h7777;
    #1;
    checks++; if (cpu_din !== 16'hBEEF) begin errors++; $display("FAIL cpu_din_hold: got %h expected beef", cpu_din); end
    checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'h7777 || mem_addr !== 16'h0070) begin errors++; $display("FAIL cpu_write: got we=%b wd=%h a=%h expected we=1 wd=7777 a=0070", mem_we, mem_wdata, mem_addr); end
    tick();
    cpu_rnw = 1'b1;
    tick();
    cpu_vda = 1'b0;
    #1;
    checks++; if (cpu_din !== 16'h7777) begin errors++; $display("FAIL cpu_readback: got %h expected 7777", cpu_din); end
    tick();
  endtask

  task automatic test_stall_hold();
    dma_addr = {16'h0000, 16'h0030}; dma_we = 2'b00;
    for (int c = 0; c < 4; c++) begin
      cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_address = 16'h0020; dma_req = 2'b01;
      #1;
      checks++; if (dma_gnt !== 2'b00 || cpu_clken !== 1'b1) begin errors++; $display("FAIL stall_pre%0d: got gnt=%b clken=%b expected gnt=00 clken=1", c, dma_gnt, cpu_clken); end
      tick();
    end
    #1;
    checks++; if (dma_gnt !== 2'b01 || cpu_clken !== 1'b0) begin errors++; $display("FAIL stall_grant: got gnt=%b clken=%b expected gnt=01 clken=0", dma_gnt, cpu_clken); end
    checks++; if (mem_addr !== 16'h0030) begin errors++; $display("FAIL stall_addr: got %h expected 0030", mem_addr); end
    checks++; if (cpu_din !== 16'hBEEF) begin errors++; $display("FAIL stall_din4: got %h expected beef", cpu_din); end
    tick();
    dma_req = 2'b00;
    #1;
    checks++; if (cpu_din !== 16'hBEEF) begin errors++; $display("FAIL stall_din5: got %h expected beef", cpu_din); end
    checks++; if (cpu_clken !== 1'b1) begin errors++; $display("FAIL stall_clken5: got %b expected 1", cpu_clken); end
    checks++; if (dma_rvalid !== 2'b01 || dma_rdata !== 16'h5555) begin errors++; $display("FAIL stall_rvalid: got rv=%b rd=%h expected rv=01 rd=5555", dma_rvalid, dma_rdata); end
    tick();
    cpu_vpa = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    dma_addr = {16'h0050, 16'h0000}; dma_we = 2'b00;
    for (int c = 0; c < 4; c++) begin
      cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_address = 16'h0010; dma_req = 2'b10;
      #1;
      checks++; if (dma_gnt !== 2'b00 || mem_addr !== 16'h0010) begin errors++; $display("FAIL starve_cpu%0d: got gnt=%b a=%h expected gnt=00 a=0010", c, dma_gnt, mem_addr); end
      tick();
    end
    #1;
    checks++; if (dma_gnt !== 2'b10 || cpu_clken !== 1'b0 || mem_addr !== 16'h0050) begin errors++; $display("FAIL starve_grant: got gnt=%b clken=%b a=%h expected gnt=10 clken=0 a=0050", dma_gnt, cpu_clken, mem_addr); end
    tick();
    dma_req = 2'b00;
    #1;
    checks++; if (dma_gnt !== 2'b00 || cpu_clken !== 1'b1 || mem_addr !== 16'h0010 || mem_ce !== 1'b1) begin errors++; $display("FAIL starve_after: got gnt=%b clken=%b a=%h ce=%b expected gnt=00 clken=1 a=0010 ce=1", dma_gnt, cpu_clken, mem_addr, mem_ce); end
    checks++; if (dma_rvalid !== 2'b10 || dma_rdata !== 16'h1111) begin errors++; $display("FAIL starve_rvalid: got rv=%b rd=%h expected rv=10 rd=1111", dma_rvalid, dma_rdata); end
    tick();
    cpu_vpa = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]  eg [4];
    logic [15:0] ed;
    eg = '{2'b01, 2'b10, 2'b01, 2'b10};
    cpu_vpa = 1'b0; cpu_vda = 1'b0;
    dma_addr = {16'h0060, 16'h0050}; dma_we = 2'b00; dma_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (dma_gnt !== eg[i] || cpu_clken !== 1'b1) begin errors++; $display("FAIL rr_gnt%0d: got gnt=%b clken=%b expected gnt=%b clken=1", i, dma_gnt, cpu_clken, eg[i]); end
      if (i > 0) begin
        ed = (eg[i-1] == 2'b01) ? 16'h1111 : 16'h2222;
        checks++; if (dma_rvalid !== eg[i-1] || dma_rdata !== ed) begin errors++; $display("FAIL rr_rv%0d: got rv=%b rd=%h expected rv=%b rd=%h", i, dma_rvalid, dma_rdata, eg[i-1], ed); end
      end
      tick();
    end
    dma_req = 2'b00;
    #1;
    checks++; if (dma_rvalid !== 2'b10 || dma_rdata !== 16'h2222 || dma_gnt !== 2'b00) begin errors++; $display("FAIL rr_last: got rv=%b rd=%h gnt=%b expected rv=10 rd=2222 gnt=00", dma_rvalid, dma_rdata, dma_gnt); end
    tick();
  endtask

  task automatic test_idle_write();
    cpu_vpa = 1'b0; cpu_vda = 1'b0;
    dma_addr = {16'h0000, 16'h0040}; dma_wdata = {16'h0000, 16'hA5A5}; dma_we = 2'b01; dma_req = 2'b01;
    #1;
    checks++; if (cpu_clken !== 1'b1 || dma_gnt !== 2'b01) begin errors++; $display("FAIL wr_grant: got clken=%b gnt=%b expected clken=1 gnt=01", cpu_clken, dma_gnt); end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 16'h0040 || mem_wdata !== 16'hA5A5) begin errors++; $display("FAIL wr_port: got we=%b a=%h wd=%h expected we=1 a=0040 wd=a5a5", mem_we, mem_addr, mem_wdata); end
    tick();
    dma_req = 2'b00; dma_we = 2'b00;
    cpu_vda = 1'b1; cpu_rnw = 1'b1; cpu_address = 16'h0040;
    #1;
    checks++; if (dma_rvalid !== 2'b00) begin errors++; $display("FAIL wr_no_rvalid: got %b expected 00", dma_rvalid); end
    tick();
    cpu_vda = 1'b0;
    #1;
    checks++; if (cpu_din !== 16'hA5A5) begin errors++; $display("FAIL wr_readback: got %h expected a5a5", cpu_din); end
    tick();
  endtask

  task automatic test_reset_mid_dma();
    cpu_vpa = 1'b0; cpu_vda = 1'b0;
    dma_addr = {16'h0000, 16'h0030}; dma_we = 2'b00; dma_req = 2'b01;
    #1;
    checks++; if (dma_gnt !== 2'b01) begin errors++; $display("FAIL rmid_grant: got %b expected 01", dma_gnt); end
    tick();
    reset = 1'b1; cpu_vpa = 1'b1; cpu_rnw = 1'b1; cpu_address = 16'h0010;
    #1;
    checks++; if (dma_rvalid !== 2'b00) begin errors++; $display("FAIL rmid_rvalid: got %b expected 00", dma_rvalid); end
    checks++; if (dma_gnt !== 2'b00 || cpu_clken !== 1'b1 || mem_ce !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_ctl1: got gnt=%b clken=%b ce=%b we=%b expected gnt=00 clken=1 ce=1 we=0", dma_gnt, cpu_clken, mem_ce, mem_we); end
    tick();
    cpu_rnw = 1'b0;
    #1;
    checks++; if (dma_gnt !== 2'b00 || cpu_clken !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_ctl2: got gnt=%b clken=%b we=%b expected gnt=00 clken=1 we=0", dma_gnt, cpu_clken, mem_we); end
    tick();
    reset = 1'b0; cpu_vpa = 1'b0; cpu_rnw = 1'b1; dma_req = 2'b00;
    #1;
    checks++; if (cpu_din !== 16'h0000 || dma_rvalid !== 2'b00) begin errors++; $display("FAIL rmid_after: got din=%h rv=%b expected din=0000 rv=00", cpu_din, dma_rvalid); end
    tick();
  endtask

  initial begin
    reset = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    cpu_address = '0; cpu_dout = '0; cpu_rnw = 1'b1; cpu_vpa = 1'b0; cpu_vda = 1'b0;
    dma_req = '0; dma_addr = '0; dma_we = '0; dma_wdata = '0;
    tick();
    preload(16'h0010, 16'h1234);
    preload(16'h0020, 16'hBEEF);
    preload(16'h0030, 16'h5555);
    preload(16'h0050, 16'h1111);
    preload(16'h0060, 16'h2222);
    test_reset();
    test_cpu_only();
    test_stall_hold();
    test_starvation();
    test_round_robin();
    test_idle_write();
    test_reset_mid_dma();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
